// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding, result-vector bit positions and the index-counter width helper.
package comparator_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit positions inside the one-hot {G, E, L} result vector.
    localparam int RES_W = 3;
    localparam int RES_G = 2;
    localparam int RES_E = 1;
    localparam int RES_L = 0;

    // The index counter must reach WIDTH-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: latches A/B on start, scans MSB first,
// stops at the first differing bit and reports one-hot G/E/L with a done strobe.
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             E,
    output logic             L
);

    localparam int IDX_W = idx_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               done_q, done_d;

    logic               a_bit;
    logic               b_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IDX_W'(WIDTH - 1);
                    res_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The first differing bit from the top decides; equal bits keep walking down.
                if (a_bit && !b_bit) begin
                    res_d[RES_G] = 1'b1;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else if (!a_bit && b_bit) begin
                    res_d[RES_L] = 1'b1;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else if (idx_q == '0) begin
                    res_d[RES_E] = 1'b1;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign G    = res_q[RES_G];
    assign E    = res_q[RES_E];
    assign L    = res_q[RES_L];

endmodule
